// File: rtl/fifo_multicanal_pkg.sv
// Shared defaults, sizing helper and error-cause tags for fifo_multicanal.
// FIFO_MULTICANAL_COUNT_EN adds the rd_count output to the top and channel controller.
package fifo_multicanal_pkg;

  localparam int DEF_MEM_SIZE  = 4;
  localparam int DEF_WORD_SIZE = 6;
  localparam int DEF_PTR_L     = 3;
  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_CH_L      = 2;

  typedef enum logic [0:0] {
    ERR_OVF = 1'b0,
    ERR_UNF = 1'b1
  } err_cause_e;

  // Bits needed to index v entries, never less than one.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_canal_ctrl.sv
// Bookkeeping for one channel: pointers, occupancy, accept decisions, flags, sticky error.
// FIFO_MULTICANAL_COUNT_EN exposes the occupancy count as an output.
module fifo_canal_ctrl
  import fifo_multicanal_pkg::*;
#(
  parameter int MEM_SIZE = DEF_MEM_SIZE,
  parameter int PTR_L    = DEF_PTR_L,
  localparam int AW      = clog2_min1(MEM_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_req,
  input  logic             rd_req,
  input  logic [PTR_L-1:0] empty_threshold,
  input  logic [PTR_L-1:0] full_threshold,
  output logic             wr_accept,
  output logic             rd_accept,
  output logic [AW-1:0]    wptr,
  output logic [AW-1:0]    rptr,
`ifdef FIFO_MULTICANAL_COUNT_EN
  output logic [PTR_L-1:0] count_out,
`endif
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic             error
);

  logic [PTR_L-1:0] count;

`ifdef FIFO_MULTICANAL_COUNT_EN
  assign count_out = count;
`endif

  assign empty        = (count == '0);
  assign full         = (count == PTR_L'(MEM_SIZE));
  assign almost_empty = !empty && (count <= empty_threshold);
  assign almost_full  = !full && (count >= full_threshold);

  // A push into a full channel survives only when a pop frees a slot in the same cycle.
  assign rd_accept = rd_req && !empty;
  assign wr_accept = wr_req && (!full || rd_accept);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      error <= 1'b0;
    end else begin
      if (wr_accept)
        wptr <= (wptr == AW'(MEM_SIZE - 1)) ? '0 : wptr + AW'(1);
      if (rd_accept)
        rptr <= (rptr == AW'(MEM_SIZE - 1)) ? '0 : rptr + AW'(1);
      if (wr_accept && !rd_accept)
        count <= count + PTR_L'(1);
      else if (rd_accept && !wr_accept)
        count <= count - PTR_L'(1);
      if ((wr_req && !wr_accept) || (rd_req && empty))
        error <= 1'b1;
    end
  end

endmodule

// File: rtl/fifo_multicanal.sv
// NUM_CH independent FIFOs sharing one register array, one write port and one read port.
// FIFO_MULTICANAL_COUNT_EN adds rd_count, the occupancy of channel rd_ch.
module fifo_multicanal
  import fifo_multicanal_pkg::*;
#(
  parameter int MEM_SIZE  = DEF_MEM_SIZE,
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int PTR_L     = DEF_PTR_L,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int CH_L      = DEF_CH_L
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] fifo_data_in,
  input  logic                 fifo_wr,
  input  logic [CH_L-1:0]      wr_ch,
  input  logic                 fifo_rd,
  input  logic [CH_L-1:0]      rd_ch,
  input  logic [PTR_L-1:0]     empty_threshold,
  input  logic [PTR_L-1:0]     full_threshold,
  output logic [WORD_SIZE-1:0] fifo_data_out,
  output logic                 data_valid,
  output logic [NUM_CH-1:0]    fifo_empty,
  output logic [NUM_CH-1:0]    fifo_full,
  output logic [NUM_CH-1:0]    almost_empty,
  output logic [NUM_CH-1:0]    almost_full,
`ifdef FIFO_MULTICANAL_COUNT_EN
  output logic [PTR_L-1:0]     rd_count,
`endif
  output logic [NUM_CH-1:0]    error
);

  localparam int AW = clog2_min1(MEM_SIZE);

  logic [WORD_SIZE-1:0] mem [NUM_CH][MEM_SIZE];
  logic [AW-1:0]        wptr_a [NUM_CH];
  logic [AW-1:0]        rptr_a [NUM_CH];
  logic [NUM_CH-1:0]    wr_req, rd_req, wr_acc, rd_acc;
  logic [WORD_SIZE-1:0] rd_word;
`ifdef FIFO_MULTICANAL_COUNT_EN
  logic [PTR_L-1:0]     count_a [NUM_CH];
`endif

  // Out-of-range channel indices match no controller, so they are silently ignored.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_req[i] = fifo_wr && (wr_ch == CH_L'(i));
    assign rd_req[i] = fifo_rd && (rd_ch == CH_L'(i));

    fifo_canal_ctrl #(
      .MEM_SIZE (MEM_SIZE),
      .PTR_L    (PTR_L)
    ) u_ctrl (
      .clk             (clk),
      .reset           (reset),
      .wr_req          (wr_req[i]),
      .rd_req          (rd_req[i]),
      .empty_threshold (empty_threshold),
      .full_threshold  (full_threshold),
      .wr_accept       (wr_acc[i]),
      .rd_accept       (rd_acc[i]),
      .wptr            (wptr_a[i]),
      .rptr            (rptr_a[i]),
`ifdef FIFO_MULTICANAL_COUNT_EN
      .count_out       (count_a[i]),
`endif
      .empty           (fifo_empty[i]),
      .full            (fifo_full[i]),
      .almost_empty    (almost_empty[i]),
      .almost_full     (almost_full[i]),
      .error           (error[i])
    );
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (wr_acc[i]) mem[i][wptr_a[i]] <= fifo_data_in;
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (rd_ch == CH_L'(i)) rd_word = mem[i][rptr_a[i]];
  end

`ifdef FIFO_MULTICANAL_COUNT_EN
  always_comb begin
    rd_count = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (rd_ch == CH_L'(i)) rd_count = count_a[i];
  end
`endif

  // A failed pop leaves the previous word on fifo_data_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_data_out <= '0;
      data_valid    <= 1'b0;
    end else begin
      data_valid <= |rd_acc;
      if (|rd_acc) fifo_data_out <= rd_word;
    end
  end

endmodule

// File: doc/fifo_multicanal.md
# fifo_multicanal

Parametrised multi-channel successor to the single FIFO memory: NUM_CH independent FIFOs share one register-array memory, one write port and one read port, each selected by a channel index. Every channel carries its own pointers, occupancy count, empty/full/almost flags and sticky error. It sits between the traffic source and the per-channel consumers and is driven by the same probador-style bench.

## Interface
- MEM_SIZE, 4, entries per channel (≥2, any value; pointers wrap modulo MEM_SIZE)
- WORD_SIZE, 6, data width in bits
- PTR_L, 3, width of thresholds and counts; must satisfy 2^PTR_L > MEM_SIZE
- NUM_CH, 4, number of channels (≥2)
- CH_L, 2, channel-select width; 2^CH_L ≥ NUM_CH
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- fifo_data_in  in  WORD_SIZE  write data
- fifo_wr  in  1  push request
- wr_ch  in  CH_L  target channel of push
- fifo_rd  in  1  pop request
- rd_ch  in  CH_L  source channel of pop
- empty_threshold  in  PTR_L  almost-empty level, shared by all channels
- full_threshold  in  PTR_L  almost-full level, shared by all channels (1..MEM_SIZE-1)
- fifo_data_out  out  WORD_SIZE  registered pop data
- data_valid  out  1  fifo_data_out holds a successful pop
- fifo_empty, fifo_full, almost_empty, almost_full  out  NUM_CH each  per-channel flags
- error  out  NUM_CH  sticky per-channel overflow/underflow flag

## Operation
- Storage: NUM_CH×MEM_SIZE words, addressed {channel, pointer}; no reset of the array contents.
- Push accepted when fifo_wr=1 and channel wr_ch not full: mem[wr_ch][wptr]←fifo_data_in, wptr+1 mod MEM_SIZE, count+1.
- Pop accepted when fifo_rd=1 and channel rd_ch not empty: fifo_data_out←mem[rd_ch][rptr], data_valid←1, rptr+1 mod MEM_SIZE, count−1.
- Push to full channel: word dropped, error[wr_ch]←1, unless a pop on the same channel is accepted the same cycle — then both proceed, count unchanged, no error.
- Pop from empty channel: error[rd_ch]←1, data_valid←0, fifo_data_out holds previous value; a simultaneous push to that channel is still accepted (no bypass).
- Push and pop on different channels in the same cycle are independent.
- wr_ch/rd_ch ≥ NUM_CH: request ignored, no error, no state change.
- Flags, combinational from count registers: fifo_empty=(count==0); fifo_full=(count==MEM_SIZE); almost_empty=(0<count≤empty_threshold); almost_full=(full_threshold≤count<MEM_SIZE).
- error bits are sticky until reset.
- Thresholds may change any cycle; flags follow immediately.

## Timing
- Reset values: fifo_data_out=0, data_valid=0, all counts/pointers 0, fifo_empty=all 1, fifo_full=0, almost_empty=0, almost_full=0, error=0.
- Reset mid-operation discards all stored words; first accepted push after deassertion lands at pointer 0.
- Push latency: word poppable on the cycle after the push edge.
- Pop latency: 1 cycle; request sampled at edge T, data and data_valid visible after edge T, valid for one cycle unless another pop is accepted.
- Flags and error update after the same edge that changes count.

## Configuration
- FIFO_MULTICANAL_COUNT_EN defined: adds output rd_count (PTR_L bits) = count of channel rd_ch, combinational; out-of-range rd_ch gives 0.
- Undefined: port absent, no extra logic.

## Structure
- Package fifo_multicanal_pkg: default parameter values, clog2-style helper, error-cause constants (ERR_OVF, ERR_UNF) for the bench.
- Sub-module fifo_canal_ctrl: one channel's wptr/rptr/count, accept logic, flags and sticky error; instantiated NUM_CH times via generate. Top holds memory array, channel decode and output register.

## Test plan
- Reset held 5 cycles, release -> fifo_empty=4'b1111, all other flags/error 0, data_valid=0.
- Push 0x11,0x22,0x33 to ch1, pop ch1 ×3 -> outputs 0x11,0x22,0x33 each one cycle after request; ch1 almost_empty=1 at count 1, fifo_empty=1 at end; other channels untouched.
- Push 5 words to ch2 (MEM_SIZE=4) -> fifo_full[2]=1 after 4th, error[2]=1 after 5th; pops return first 4 words only.
- Ch3 full, simultaneous push 0x3F and pop ch3 -> count stays 4, no error, 0x3F returned as 4th subsequent pop.
- Pop ch0 while empty with push 0x05 to ch0 same cycle -> error[0]=1, data_valid=0, next pop returns 0x05.
- Reset asserted with ch1 holding 2 words -> all flags back to reset values asynchronously; post-reset pop of ch1 raises error[1].
